// File: rtl/pc_seq_pkg.sv
// Shared constants and state encoding for the fetch-stage PC sequencer.
package pc_seq_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned OPC_HI  = 15;
    localparam int unsigned OPC_LO  = 12;
    localparam int unsigned OPC_W   = OPC_HI - OPC_LO + 1;
    localparam int unsigned DRAIN_W = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_HALTING  = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

endpackage

// File: rtl/pc_incr.sv
// Sequential-fetch incrementer: PC + 2, wrapping modulo 2^16.
module pc_incr
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    output logic [PC_W-1:0] pc_plus2_o
);

    assign pc_plus2_o = pc_i + PC_W'(2);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: advance / redirect / wait / halt control and IF/ID gating.
// Optional feature macro PC_SEQ_PERF_EN adds saturating fetch and redirect counters.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0]  RESET_PC    = 16'h0000,
    parameter logic [OPC_W-1:0] HALT_OPCODE = 4'hF,
    parameter int unsigned      HALT_DRAIN  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] instr,
    input  logic            imem_valid,
    input  logic            hazard_stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_plus2,
    output logic            fetch_valid,
    output logic            if_id_wen,
    output logic            if_id_flush,
`ifdef PC_SEQ_PERF_EN
    output logic [15:0]     perf_fetch_cnt,
    output logic [15:0]     perf_redirect_cnt,
`endif
    output logic            halted
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 halted_q, halted_d;

    logic                 br_acc_c;
    logic                 halt_op_c;
    logic                 in_fetch_c;
    logic                 redir_acc_c;
    logic                 unused_instr_c;

    pc_incr u_pc_incr (
        .pc_i       (pc_q),
        .pc_plus2_o (pc_plus2)
    );

    assign br_acc_c       = br_taken & ~hazard_stall;
    assign halt_op_c      = (instr[OPC_HI:OPC_LO] == HALT_OPCODE);
    assign unused_instr_c = ^instr[OPC_LO-1:0];
    assign in_fetch_c     = (state_q == ST_RUN) || (state_q == ST_WAIT_MEM);
    assign redir_acc_c    = br_acc_c & (state_q != ST_HALTED);

    assign fetch_valid = imem_valid & ~hazard_stall & ~br_taken & in_fetch_c;
    assign if_id_wen   = ~hazard_stall;
    assign if_id_flush = if_id_wen & ~fetch_valid;
    assign pc_out      = pc_q;
    assign halted      = halted_q;

    // Next-state: stall > redirect > memory wait > halt fetch > sequential advance
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        drain_d  = drain_q;
        halted_d = halted_q;
        case (state_q)
            ST_RUN, ST_WAIT_MEM: begin
                if (hazard_stall) begin
                    state_d = state_q;
                end else if (br_taken) begin
                    pc_d    = br_target;
                    state_d = ST_RUN;
                end else if (!imem_valid) begin
                    state_d = ST_WAIT_MEM;
                end else if (halt_op_c) begin
                    state_d = ST_HALTING;
                    drain_d = DRAIN_W'(HALT_DRAIN - 1);
                end else begin
                    pc_d    = pc_plus2;
                    state_d = ST_RUN;
                end
            end
            ST_HALTING: begin
                // A resolved branch here means the halt was on the wrong path
                if (br_acc_c) begin
                    pc_d    = br_target;
                    state_d = ST_RUN;
                end else if (drain_q == '0) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            drain_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drain_q  <= drain_d;
            halted_q <= halted_d;
        end
    end

`ifdef PC_SEQ_PERF_EN
    logic [15:0] perf_fetch_q, perf_fetch_d;
    logic [15:0] perf_redir_q, perf_redir_d;

    // Saturating event counters; both events are impossible in HALTED, so they freeze there
    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_redir_d = perf_redir_q;
        if (fetch_valid && (perf_fetch_q != 16'hFFFF)) begin
            perf_fetch_d = perf_fetch_q + 16'd1;
        end
        if (redir_acc_c && (perf_redir_q != 16'hFFFF)) begin
            perf_redir_d = perf_redir_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_redir_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    assign perf_fetch_cnt    = perf_fetch_q;
    assign perf_redirect_cnt = perf_redir_q;
`else
    logic unused_redir_c;
    assign unused_redir_c = redir_acc_c;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that owns the 16-bit program counter and decides every cycle whether it advances by 2, loads a branch target, holds, or freezes on halt. Sits between the instruction memory, the hazard unit and the ID-stage branch resolver. Drives the IF/ID pipeline register's write-enable and flush so that wrong-path, stalled and memory-wait fetches never enter the pipeline.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- HALT_OPCODE, 4'hF, value of instr[15:12] that marks HLT
- HALT_DRAIN, 4, cycles between halt fetch and `halted`; legal range 1..7
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  16  instruction word read at pc_out
- imem_valid  in  1  instr is valid this cycle
- hazard_stall  in  1  hazard unit: hold PC and IF/ID
- br_taken  in  1  ID stage: branch resolved taken
- br_target  in  16  ID stage: branch target address
- pc_out  out  16  current PC, registered
- pc_plus2  out  16  pc_out + 2, wraps mod 2^16
- fetch_valid  out  1  instr is a valid in-path fetch to latch
- if_id_wen  out  1  IF/ID register write enable
- if_id_flush  out  1  load NOP into IF/ID
- halted  out  1  processor halted, registered

## Operation
- States: RUN, WAIT_MEM, HALTING, HALTED. Reset state RUN, pc_out=RESET_PC, drain counter 0, halted=0.
- br_taken is ignored while hazard_stall=1.
- Priority, per cycle in RUN or WAIT_MEM: hazard_stall (hold PC, stay) > br_taken (PC<=br_target, go RUN) > !imem_valid (hold PC, go/stay WAIT_MEM) > instr[15:12]==HALT_OPCODE (hold PC, go HALTING, load drain counter with HALT_DRAIN-1) > PC<=pc_plus2, stay RUN.
- HALTING: PC held. br_taken cancels the halt as wrong-path: PC<=br_target, go RUN. Otherwise the counter decrements; when it reads 0, go HALTED.
- HALTED: PC held, all inputs ignored until rst; halted=1.
- fetch_valid = imem_valid & !hazard_stall & !br_taken, and the state is RUN or WAIT_MEM. The halt instruction itself is fetched valid.
- if_id_wen = !hazard_stall.
- if_id_flush = if_id_wen & !fetch_valid. This covers redirects, memory waits, HALTING and HALTED.
- Arithmetic: 16-bit unsigned, PC+2 wraps 16'hFFFE to 16'h0000. br_target is used unmodified, including odd values.

## Timing
- pc_out and halted are registered. All other outputs are combinational from state and inputs; no input-to-input combinational path.
- Redirect latency: br_taken in cycle N gives pc_out=br_target in N+1. The fetch in N is flushed.
- Halt latency: halt fetched in cycle N gives halted=1 in N+HALT_DRAIN+1.
- Asserting rst in any state, including mid-wait or HALTING, forces all reset values immediately. The first fetch occurs in the first clock after deassertion.
- Simultaneous events: hazard_stall plus br_taken means stall wins and the branch is re-presented by ID. br_taken plus a halt fetch means the redirect wins and the halt is flushed.

## Configuration
- PC_SEQ_PERF_EN defined: adds two outputs.
  - perf_fetch_cnt[15:0]: +1 per cycle with fetch_valid=1.
  - perf_redirect_cnt[15:0]: +1 per accepted br_taken.
  - Both saturate at 16'hFFFF, reset to 0 and freeze in HALTED.
- Not defined: both ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package pc_seq_pkg holds:
  - state encoding (2 bits: RUN=0, WAIT_MEM=1, HALTING=2, HALTED=3)
  - opcode field position constants [15:12]
  - PC width constant 16
- One sub-module, pc_incr: a 16-bit +2 incrementer producing pc_plus2.
- The PC state itself is 16 async-reset flops with enable, local to the block.

## Test plan
- Reset release with RESET_PC=16'h0000, imem_valid=1, non-halt instrs -> pc_out 0,2,4,6; fetch_valid=1; if_id_flush=0.
- br_taken=1, br_target=16'h0100 at pc_out=16'h0008 -> next pc_out=16'h0100; if_id_flush=1 that cycle. With PC_SEQ_PERF_EN defined, perf_redirect_cnt=1.
- imem_valid=0 for 3 cycles at pc_out=16'h0010 -> state WAIT_MEM; pc_out held at 16'h0010; if_id_flush=1 for 3 cycles; then resumes to 16'h0012.
- hazard_stall=1 with br_taken=1 -> pc_out held; if_id_wen=0; redirect occurs only once the stall drops.
- Halt instr 16'hF000 at pc_out=16'h0020, HALT_DRAIN=4 -> halted=1 five cycles later; pc_out stays 16'h0020. rst then restores pc_out=16'h0000 and halted=0.
- pc_out=16'hFFFE with a valid non-halt fetch -> pc_out wraps to 16'h0000.
